// File: rtl/id_fsm_pkg.sv
// Shared state encoding and character-class boundaries for the identifier recognizer.
package id_fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ALPHA = 2'b01,
    ST_DIGIT = 2'b10
  } state_e;

  localparam logic [7:0] UPPER_LO = 8'h41;
  localparam logic [7:0] UPPER_HI = 8'h5A;
  localparam logic [7:0] LOWER_LO = 8'h61;
  localparam logic [7:0] LOWER_HI = 8'h7A;
  localparam logic [7:0] DIGIT_LO = 8'h30;
  localparam logic [7:0] DIGIT_HI = 8'h39;

  function automatic logic in_range(input logic [7:0] c,
                                    input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/char_class.sv
// Combinational ASCII classifier: letter, digit, or neither (other).
module char_class
  import id_fsm_pkg::*;
(
  input  logic [7:0] char,
  output logic       is_letter,
  output logic       is_digit
);

  always_comb begin
    is_letter = in_range(char, UPPER_LO, UPPER_HI) || in_range(char, LOWER_LO, LOWER_HI);
    is_digit  = in_range(char, DIGIT_LO, DIGIT_HI);
  end

endmodule

// File: rtl/id_fsm.sv
// Identifier recognizer: out is high while the stream since the last break
// is a letter prefix followed by one or more digits.
//
// state    | meaning
// ---------+-------------------------------------------
// ST_IDLE  | no letter prefix
// ST_ALPHA | one or more letters seen, no digit yet
// ST_DIGIT | letter prefix followed by one or more digits
module id_fsm
  import id_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] char,
  output logic       out
);

  logic   is_letter;
  logic   is_digit;
  state_e state_q;
  state_e state_d;

  char_class u_char_class (
    .char      (char),
    .is_letter (is_letter),
    .is_digit  (is_digit)
  );

  always_comb begin
    state_d = ST_IDLE;
    unique case (state_q)
      ST_IDLE: begin
        if (is_letter) state_d = ST_ALPHA;
      end
      ST_ALPHA: begin
        if (is_letter)     state_d = ST_ALPHA;
        else if (is_digit) state_d = ST_DIGIT;
      end
      ST_DIGIT: begin
        if (is_digit)       state_d = ST_DIGIT;
        else if (is_letter) state_d = ST_ALPHA;
      end
      // The spare encoding falls back to IDLE, where out is 0.
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  assign out = (state_q == ST_DIGIT);

endmodule

// File: tb/tb_id_fsm.sv
// Directed self-checking bench for id_fsm.
module tb_id_fsm;

  logic       clk;
  logic       reset;
  logic [7:0] char;
  logic       out;

  int n_tests = 0;
  int n_fail  = 0;

  id_fsm dut (
    .clk   (clk),
    .reset (reset),
    .char  (char),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic exp);
    n_tests++;
    assert (out === exp) else begin
      n_fail++;
      $error("FAIL %s: out=%b expected=%b", tag, out, exp);
    end
  endtask

  task automatic step(input string tag, input logic [7:0] c, input logic exp);
    char = c;
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check({tag, "_rst"}, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [7:0] brk [7];

  initial begin
    reset = 1'b1;
    char  = 8'h00;
    brk = '{8'h2F, 8'h3A, 8'h40, 8'h5B, 8'h60, 8'h7B, 8'hC1};
    #2;
    check("reset_initial", 1'b0);
    @(negedge clk);
    reset = 1'b0;

    step("ab12_a", "a", 1'b0);
    step("ab12_b", "b", 1'b0);
    step("ab12_1", "1", 1'b1);
    step("ab12_2", "2", 1'b1);

    do_reset("seq2");
    step("1a_3_1", "1", 1'b0);
    step("1a_3_a", "a", 1'b0);
    step("1a_3__", 8'h5F, 1'b0);
    step("1a_3_3", "3", 1'b0);

    do_reset("seq3");
    step("x9y7_x", "x", 1'b0);
    step("x9y7_9", "9", 1'b1);
    step("x9y7_y", "y", 1'b0);
    step("x9y7_7", "7", 1'b1);

    // A boundary code from ALPHA must land in IDLE: a following digit then keeps out low.
    for (int i = 0; i < 7; i++) begin
      do_reset("bnd");
      step("bnd_alpha", "a", 1'b0);
      step($sformatf("bnd_%02h", brk[i]), brk[i], 1'b0);
      step($sformatf("bnd_%02h_idle", brk[i]), "5", 1'b0);
    end
    do_reset("dlo");
    step("dlo_alpha", "a", 1'b0);
    step("dlo_30", 8'h30, 1'b1);
    do_reset("dhi");
    step("dhi_alpha", "a", 1'b0);
    step("dhi_39", 8'h39, 1'b1);

    do_reset("async");
    step("async_Z", "Z", 1'b0);
    step("async_0", "0", 1'b1);
    reset = 1'b1;
    #1;
    check("async_drop", 1'b0);
    #1;
    reset = 1'b0;
    #1;
    check("async_held", 1'b0);
    step("async_after_0", "0", 1'b0);

    do_reset("hold");
    for (int i = 0; i < 5; i++) step($sformatf("hold_q%0d", i), "q", 1'b0);
    for (int i = 0; i < 3; i++) step($sformatf("hold_4_%0d", i), "4", 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
